// File: rtl/axi_read_arbiter_pkg.sv
// Shared types for the two-master AXI4-Lite read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    localparam int ARB_N = 2;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) with master/slave views.
interface if_axi_read #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid,
        output araddr,
        output rready,
        input  arready,
        input  rvalid,
        input  rdata,
        input  rresp
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  rready,
        output arready,
        output rvalid,
        output rdata,
        output rresp
    );

endinterface

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the master not served
// last wins, otherwise the single requester is chosen.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic             last,
    output logic             gnt_idx,
    output logic             any
);

    always_comb begin
        any     = |req;
        gnt_idx = 1'b0;
        if (req[1] && (!req[0] || !last)) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4-Lite read slave between the IFU (in0) and LSU (in1),
// one transaction in flight, round-robin between the two masters.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    if_axi_read.slave  in0,
    if_axi_read.slave  in1,
    if_axi_read.master out
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              owner;
    logic              last;
    logic              gnt_idx;
    logic              any_valid;
    logic              owner_rready;

    rr_arb2 u_rr_arb2 (
        .req     ({in1.arvalid, in0.arvalid}),
        .last    (last),
        .gnt_idx (gnt_idx),
        .any     (any_valid)
    );

    assign owner_rready = owner ? in1.rready : in0.rready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ARB_IDLE;
            addr_q  <= '0;
            owner   <= 1'b0;
            last    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && any_valid) begin
                addr_q <= gnt_idx ? in1.araddr : in0.araddr;
                owner  <= gnt_idx;
            end
            if (state_q == ARB_DATA && out.rvalid && owner_rready) begin
                last <= owner;
            end
        end
    end

    // Grants are qualified by reset so nothing handshakes while it is held.
    always_comb begin
        state_d     = state_q;
        in0.arready = 1'b0;
        in1.arready = 1'b0;
        out.arvalid = 1'b0;
        out.araddr  = '0;
        out.rready  = 1'b0;
        in0.rvalid  = 1'b0;
        in0.rdata   = '0;
        in0.rresp   = '0;
        in1.rvalid  = 1'b0;
        in1.rdata   = '0;
        in1.rresp   = '0;

        case (state_q)
            ARB_IDLE: begin
                in0.arready = i_reset_n && any_valid && !gnt_idx;
                in1.arready = i_reset_n && any_valid && gnt_idx;
                if (any_valid) begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                out.arvalid = 1'b1;
                out.araddr  = addr_q;
                if (out.arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                out.rready = owner_rready;
                if (owner) begin
                    in1.rvalid = out.rvalid;
                    in1.rdata  = out.rdata;
                    in1.rresp  = out.rresp;
                end else begin
                    in0.rvalid = out.rvalid;
                    in0.rdata  = out.rdata;
                    in0.rresp  = out.rresp;
                end
                if (out.rvalid && owner_rready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master, one-slave AXI4-Lite read-channel arbiter that shares a single `if_axi_read` slave (CLINT, SRAM or the downstream crossbar) between the instruction fetch unit (port 0) and the load/store unit (port 1). It accepts one upstream read address at a time, issues it downstream, and routes the read response back to the owning master. Arbitration is round-robin, and at most one transaction is outstanding. The block sits between the core's fetch/LSU read masters and the memory-side read interconnect.

## Interface
Parameters:
- `ADDR_W`, 32, address width of `araddr` on all ports.
- `DATA_W`, 32, data width of `rdata` on all ports.

Ports:
- `i_clock`  in  1  single clock; everything is rising-edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `in0`  if_axi_read.slave  bundle  IFU read master; lower index.
- `in1`  if_axi_read.slave  bundle  LSU read master.
- `out`  if_axi_read.master  bundle  shared downstream read slave.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`. Reset state is `IDLE`.
- **IDLE**
  - The grant index `g` comes from a combinational 2-way round-robin picker over `{in1.arvalid, in0.arvalid}`.
  - Priority goes to the master not served last. `last` resets to 1, so `in0` wins the first tie.
  - `inX.arready = (state==IDLE) && any_valid && g==X`. The non-granted master sees `arready=0`.
  - On the upstream handshake: latch `araddr` into `addr_q`, latch `g` into `owner`, then go to `ADDR`.
- **ADDR**
  - `out.arvalid=1` and `out.araddr=addr_q`.
  - On `out.arready`, go to `DATA`. `out.arvalid` is held until the handshake and `addr_q` stays stable.
- **DATA**
  - `out.rready = in[owner].rready`.
  - `in[owner].rvalid = out.rvalid`.
  - `in[owner].rdata` and `in[owner].rresp` are passed through unchanged. Error responses are not altered.
  - On `out.rvalid && out.rready`: `last <= owner`, then go to `IDLE`.
- Outside `DATA`: `out.rready=0`, and both `inX.rvalid=0`.
- The non-owner master always sees `rvalid=0`, `rdata=0`, `rresp=0`.
- Requirement on masters: they must hold `arvalid`/`araddr` stable until `arready`. The arbiter does not retract a grant within `IDLE` because the decision is made in the handshake cycle.
- Async reset at any point forces these values, and any in-flight downstream transaction is abandoned:
  - `IDLE`
  - `last=1`
  - `owner=0`
  - `addr_q=0`
  - all outputs 0

## Timing
- Reset values: `out.arvalid=0`, `out.araddr=0`, `out.rready=0`, `inX.arready=0`, `inX.rvalid=0`, `inX.rdata=0`, `inX.rresp=0`.
- Upstream handshake in cycle T means `out.arvalid` is high in T+1.
- Downstream `arready` in cycle T+k means `DATA` starts in T+k+1.
- The response is combinational pass-through in `DATA`, adding zero cycles.
- After the response handshake in cycle R, `IDLE` is in R+1. The earliest next upstream `arready` is R+1.
- Minimum request-to-response-accept turnaround is 3 cycles with a zero-wait slave that registers its `arready` and `rvalid`.
- Simultaneous requests:
  - Both arrive in `IDLE`: the non-`last` master is granted; the other waits, stalled by `arready=0`.
  - A master that re-requests every cycle alternates with the other one, so neither starves.
- Back-pressure: `in[owner].rready=0` holds the arbiter in `DATA` indefinitely. No timeout.

## Structure
- The shared package `axi_arb_pkg` holds:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t`
  - `localparam ARB_N = 2`
- One sub-module, `rr_arb2`, is purely combinational. Its inputs are `req[1:0]` and `last`. Its outputs are `gnt_idx` and `any`.
- The top holds:
  - the FSM
  - `addr_q`, `owner` and `last` registers
  - response muxing

## Test plan
- **Reset and idle:** assert `i_reset_n=0` mid-`DATA` → next sample shows all outputs 0 and state `IDLE`. After release, an `in1`-only request at 0x0200_BFF8 is granted.
- **Single read:** `in0` reads 0x8000_0004; the slave returns `rdata=0xDEADBEEF`, `rresp=0` → `in0` sees the data with `rvalid`, `in1.rvalid` stays 0, and `out.araddr=0x8000_0004` one cycle after the handshake.
- **Simultaneous requests after reset:** `in0`@0x100 and `in1`@0x200 → `in0` is served first, then `in1`. The `out.araddr` order is 0x100, 0x200.
- **Fairness:** both masters request continuously for 8 transactions → the grant order is 0,1,0,1,0,1,0,1.
- **Back-pressure and wait states:** the slave delays `arready` 3 cycles and `rvalid` 2 cycles; the owner holds `rready=0` for 4 cycles → `addr_q` is stable, `out.arvalid` is held, no second grant happens, and data is delivered once `rready` rises.
- **Error pass-through:** the slave returns `rresp=2'b10` for `in1` → `in1.rresp=2'b10`. The next transaction proceeds normally.
